// File: rtl/increment_button_controller.sv
// Set-button front end: synchronises and debounces the raw button, issues one
// increment strobe per accepted press and auto-repeats after a long hold.
module increment_button_controller #(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned HOLD_TICKS     = 50,
    parameter int unsigned REPEAT_TICKS   = 10
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Tick,
    input  logic i_Button,
    input  logic i_Enable,
    output logic o_Increment,
    output logic o_Pressed,
    output logic o_Repeating
);

    localparam int unsigned MAX_DH    = (DEBOUNCE_TICKS > HOLD_TICKS) ? DEBOUNCE_TICKS : HOLD_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_DH > REPEAT_TICKS) ? MAX_DH : REPEAT_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);

    localparam logic [2:0] S_RELEASED   = 3'd0;
    localparam logic [2:0] S_PRESS_DB   = 3'd1;
    localparam logic [2:0] S_HELD       = 3'd2;
    localparam logic [2:0] S_REPEAT     = 3'd3;
    localparam logic [2:0] S_RELEASE_DB = 3'd4;

    logic          sync_q1;
    logic          btn_s;
    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          strobe_c;
    logic          deb_done_c;
    logic          hold_done_c;
    logic          rep_done_c;
    logic          pressed_next_c;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_q1 <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync_q1 <= i_Button;
            btn_s   <= sync_q1;
        end
    end

    assign deb_done_c  = i_Tick && (cnt == CW'(DEBOUNCE_TICKS - 1));
    assign hold_done_c = i_Tick && (cnt == CW'(HOLD_TICKS - 1));
    assign rep_done_c  = i_Tick && (cnt == CW'(REPEAT_TICKS - 1));

    // Next-state, tick counter and strobe decode; a falling btn_s beats a due strobe
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        strobe_c   = 1'b0;
        case (state)
            S_RELEASED: begin
                cnt_next = '0;
                if (btn_s) begin
                    state_next = S_PRESS_DB;
                end
            end
            S_PRESS_DB: begin
                if (!btn_s) begin
                    state_next = S_RELEASED;
                    cnt_next   = '0;
                end else if (deb_done_c) begin
                    state_next = S_HELD;
                    cnt_next   = '0;
                    strobe_c   = 1'b1;
                end else if (i_Tick) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_next = S_RELEASE_DB;
                    cnt_next   = '0;
                end else if (hold_done_c) begin
                    state_next = S_REPEAT;
                    cnt_next   = '0;
                    strobe_c   = 1'b1;
                end else if (i_Tick) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_REPEAT: begin
                if (!btn_s) begin
                    state_next = S_RELEASE_DB;
                    cnt_next   = '0;
                end else if (rep_done_c) begin
                    cnt_next = '0;
                    strobe_c = 1'b1;
                end else if (i_Tick) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_RELEASE_DB: begin
                if (btn_s) begin
                    cnt_next = '0;
                end else if (deb_done_c) begin
                    state_next = S_RELEASED;
                    cnt_next   = '0;
                end else if (i_Tick) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = S_RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    assign pressed_next_c = (state_next == S_HELD) || (state_next == S_REPEAT) ||
                            (state_next == S_RELEASE_DB);

    // State, counter and registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_RELEASED;
            cnt         <= '0;
            o_Increment <= 1'b0;
            o_Pressed   <= 1'b0;
            o_Repeating <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            // Masking with the previous strobe keeps pulses apart even at 1-tick periods
            o_Increment <= strobe_c && i_Enable && !o_Increment;
            o_Pressed   <= pressed_next_c;
            o_Repeating <= (state_next == S_REPEAT);
        end
    end

endmodule

// File: tb/tb_increment_button_controller.sv
// Directed bench for increment_button_controller with default parameters.
module tb_increment_button_controller;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b0;
    logic i_Tick = 1'b1;
    logic i_Button = 1'b0;
    logic i_Enable = 1'b1;
    logic o_Increment;
    logic o_Pressed;
    logic o_Repeating;

    int tests = 0;
    int fails = 0;
    int e = 0;
    int tick_div = 1;
    int b2b = 0;
    logic inc_h [0:511];
    logic prs_h [0:511];
    logic rep_h [0:511];

    increment_button_controller dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Tick     (i_Tick),
        .i_Button   (i_Button),
        .i_Enable   (i_Enable),
        .o_Increment(o_Increment),
        .o_Pressed  (o_Pressed),
        .o_Repeating(o_Repeating)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges; history index = edge number since e was last cleared
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            i_Tick = (tick_div == 1) ? 1'b1 : (((e + 1) % tick_div) == 0);
            @(posedge i_Clock);
            #1;
            if (e < 511) e++;
            inc_h[e] = o_Increment;
            prs_h[e] = o_Pressed;
            rep_h[e] = o_Repeating;
            if (o_Increment && e > 1 && inc_h[e-1]) b2b++;
        end
    endtask

    function automatic int count_inc(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (inc_h[k]) c++;
        return c;
    endfunction

    function automatic int count_prs(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (prs_h[k]) c++;
        return c;
    endfunction

    function automatic int count_rep(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (rep_h[k]) c++;
        return c;
    endfunction

    initial begin
        for (int k = 0; k < 512; k++) begin
            inc_h[k] = 1'b0;
            prs_h[k] = 1'b0;
            rep_h[k] = 1'b0;
        end

        // Reset held 3 cycles with the button pressed
        i_Button = 1'b1;
        i_Reset  = 1'b1;
        e = 0;
        run(3);
        check("rst_inc", int'(o_Increment), 0);
        check("rst_prs", int'(o_Pressed), 0);
        check("rst_rep", int'(o_Repeating), 0);
        i_Reset = 1'b0;
        e = 0;
        run(20);
        check("rst_first_strobe_e7", int'(inc_h[7]), 1);
        check("rst_strobe_width", int'(inc_h[8]), 0);
        check("rst_strobe_count", count_inc(1, 20), 1);
        i_Button = 1'b0;
        e = 0;
        run(12);

        // Clean single press held 20 cycles
        i_Button = 1'b1;
        e = 0;
        run(20);
        check("clean_count", count_inc(1, 20), 1);
        check("clean_strobe_e7", int'(inc_h[7]), 1);
        check("clean_prs_e6", int'(prs_h[6]), 0);
        check("clean_prs_e7", int'(prs_h[7]), 1);
        check("clean_rep", count_rep(1, 20), 0);
        i_Button = 1'b0;
        e = 0;
        run(12);
        check("clean_rel_prs_e6", int'(prs_h[6]), 1);
        check("clean_rel_prs_e7", int'(prs_h[7]), 0);
        check("clean_rel_inc", count_inc(1, 12), 0);

        // Short bounce then 1-0-1-0 chatter
        i_Button = 1'b1;
        e = 0;
        run(2);
        i_Button = 1'b0;
        run(8);
        for (int k = 0; k < 4; k++) begin
            i_Button = (k % 2 == 0);
            run(1);
        end
        i_Button = 1'b0;
        run(10);
        check("bounce_inc", count_inc(1, e), 0);
        check("bounce_prs", count_prs(1, e), 0);

        // Long hold with auto-repeat
        i_Button = 1'b1;
        e = 0;
        run(100);
        check("long_count", count_inc(1, 100), 6);
        check("long_e7", int'(inc_h[7]), 1);
        check("long_e57", int'(inc_h[57]), 1);
        check("long_e67", int'(inc_h[67]), 1);
        check("long_e77", int'(inc_h[77]), 1);
        check("long_e87", int'(inc_h[87]), 1);
        check("long_e97", int'(inc_h[97]), 1);
        check("long_rep_e56", int'(rep_h[56]), 0);
        check("long_rep_e57", int'(rep_h[57]), 1);
        check("long_rep_e100", int'(rep_h[100]), 1);
        i_Button = 1'b0;
        e = 0;
        run(12);
        check("long_rel_rep_e2", int'(rep_h[2]), 1);
        check("long_rel_rep_e3", int'(rep_h[3]), 0);
        check("long_rel_prs_e3", int'(prs_h[3]), 1);
        check("long_rel_prs_e7", int'(prs_h[7]), 0);
        check("long_rel_inc", count_inc(1, 12), 0);

        // Enable low through the hold, raised at cycle 60
        i_Enable = 1'b0;
        i_Button = 1'b1;
        e = 0;
        run(60);
        check("dis_inc_none", count_inc(1, 60), 0);
        check("dis_prs_e7", int'(prs_h[7]), 1);
        check("dis_rep_e57", int'(rep_h[57]), 1);
        i_Enable = 1'b1;
        run(40);
        check("dis_resume_e67", int'(inc_h[67]), 1);
        check("dis_resume_count", count_inc(61, 100), 4);
        i_Button = 1'b0;
        e = 0;
        run(12);

        // Slow tick (every 4th cycle), then reset while in repeat
        tick_div = 4;
        i_Button = 1'b1;
        e = 0;
        run(230);
        check("slow_e15", int'(inc_h[15]), 0);
        check("slow_e16", int'(inc_h[16]), 1);
        check("slow_rep_e215", int'(rep_h[215]), 0);
        check("slow_e216", int'(inc_h[216]), 1);
        check("slow_count", count_inc(1, 230), 2);
        run(1);
        i_Reset = 1'b1;
        run(1);
        check("slow_rst_inc", int'(o_Increment), 0);
        check("slow_rst_prs", int'(o_Pressed), 0);
        check("slow_rst_rep", int'(o_Repeating), 0);
        i_Reset = 1'b0;
        e = 0;
        run(24);
        check("slow_rerun_prs_e15", int'(prs_h[15]), 0);
        check("slow_rerun_e16", int'(inc_h[16]), 1);
        check("slow_rerun_count", count_inc(1, 24), 1);

        check("no_back_to_back", b2b, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/increment_button_controller.md
# increment_button_controller

Converts the raw "set" push-button into clean, single-cycle increment strobes for the minute and hour counters while the clock is in a setting mode. It synchronises and debounces the button, emits one strobe per press, and auto-repeats after a long hold. It sits between the board button and the counters' increment input. `control_unit` gates it through its increment-enable output.

## Interface
Parameters:
- DEBOUNCE_TICKS, 4: number of i_Tick strobes the button level must stay stable to accept a press or release (>=1).
- HOLD_TICKS, 50: number of i_Tick strobes held after an accepted press before auto-repeat starts (>=1).
- REPEAT_TICKS, 10: number of i_Tick strobes between auto-repeat strobes (>=1).

Ports:
- i_Clock  in  1  single system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Tick  in  1  single-cycle time-base strobe; all timing counts only cycles with i_Tick=1.
- i_Button  in  1  raw asynchronous button, active high.
- i_Enable  in  1  increment permission, driven from control_unit's o_Counters_Enable_Increment.
- o_Increment  out  1  registered single-cycle increment strobe.
- o_Pressed  out  1  debounced button level.
- o_Repeating  out  1  high while in auto-repeat.

## Operation
- Synchroniser: 2-FF on i_Button gives btn_s. btn_s lags i_Button by 2 edges. Only btn_s is used after this point.
- One tick counter `cnt`, width $clog2(max parameter + 1). It clears to 0 on every state change.
- Ticks: `cnt` advances only when i_Tick=1. "N ticks elapsed" means the edge where i_Tick=1 and cnt==N-1.
- FSM states and transitions:
  - RELEASED: btn_s=1 -> PRESS_DB.
  - PRESS_DB: btn_s=0 -> RELEASED (bounce rejected, no strobe). DEBOUNCE_TICKS elapsed with btn_s=1 -> HELD, strobe.
  - HELD: btn_s=0 -> RELEASE_DB. HOLD_TICKS elapsed -> REPEAT, strobe.
  - REPEAT: btn_s=0 -> RELEASE_DB. REPEAT_TICKS elapsed -> stay in REPEAT, clear cnt, strobe.
  - RELEASE_DB: btn_s=1 -> clear cnt and stay (the release must be continuously low). DEBOUNCE_TICKS elapsed with btn_s=0 -> RELEASED. No strobes in this state.
- Strobe: o_Increment is set to i_Enable (sampled at the same edge) on every strobe edge, and 0 on all other edges. It is never high for two consecutive cycles.
- i_Enable=0 suppresses strobes only; the FSM keeps running. If i_Enable rises mid-hold, the next repeat strobe passes.
- If btn_s falls on the same edge a strobe is due: the btn_s=0 transition wins and no strobe is issued.
- o_Pressed = state is HELD, REPEAT or RELEASE_DB.
- o_Repeating = state is REPEAT.
- Reset (including mid-operation): state RELEASED, cnt=0, sync FFs=0, o_Increment=0, o_Pressed=0, o_Repeating=0. A button still held after reset is re-debounced and produces a fresh first strobe.

## Timing
- With i_Tick tied high and i_Button rising before edge 1:
  - btn_s=1 after edge 2.
  - PRESS_DB from edge 3.
  - HELD and first o_Increment in the cycle after edge 3+DEBOUNCE_TICKS.
- First repeat strobe comes HOLD_TICKS ticks later. Later repeat strobes are every REPEAT_TICKS ticks.
- Release latency (i_Tick high): o_Pressed falls 2 + 1 + DEBOUNCE_TICKS edges after i_Button falls.
- All outputs are registered or pure state decode. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use defaults 4/50/10 and i_Tick=1 unless noted.
- Reset: i_Reset=1 for 3 cycles with i_Button=1 -> all outputs 0. After release, first o_Increment is 1 for exactly one cycle after edge 7 counted from reset deassertion.
- Clean press, i_Enable=1, held 20 cycles -> exactly one o_Increment after edge 7. o_Pressed is 1 from edge 7 and falls 7 edges after i_Button drops. o_Repeating stays 0.
- Bounce: i_Button high 2 cycles then low -> zero strobes, o_Pressed stays 0. Then 1-0-1-0 chatter at 1-cycle intervals -> zero strobes.
- Long hold of 100 cycles -> strobes after edges 7, 57, 67, 77, 87, 97 (6 total). o_Repeating is 1 from edge 57 until RELEASE_DB.
- i_Enable=0 for the whole hold -> zero strobes, o_Pressed and o_Repeating are unchanged from the enabled case. Raising i_Enable at cycle 60 -> strobes resume at edge 67.
- i_Tick every 4th cycle plus i_Reset during REPEAT:
  - Debounce takes 4 strobes (about 16 cycles) and the pulse count matches the tick count.
  - Reset in REPEAT -> outputs 0 on the next cycle.
  - With the button still held after reset -> first strobe after a new debounce interval.
